// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the MINIRISC-V core: sequences FETCH/DECODE/EXEC/MEM/WB
// with imem/dmem req/ready handshakes, a wait watchdog, and illegal-opcode halting.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ENABLE_AUIPC   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] npc_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       alu_a_pc,
    output logic       offset_origin,
    output logic [2:0] state_o,
    output logic       illegal_instr,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } class_e;

    state_e             state_q, state_d;
    class_e             class_q, class_d, dec_class;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               wait_hit;
    logic [1:0]         f_npc, f_m2r;
    logic               f_src, f_apc, f_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Opcode classification; C_NONE marks an illegal instruction.
    always_comb begin
        dec_class = C_NONE;
        case (opcode)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b0110111: dec_class = C_LUI;
            7'b0010111: dec_class = ENABLE_AUIPC ? C_AUIPC : C_NONE;
            default:    dec_class = C_NONE;
        endcase
    end

    // Per-class datapath fields, driven only while an instruction is past DECODE.
    always_comb begin
        f_npc = 2'b00;
        f_m2r = 2'b00;
        f_src = 1'b0;
        f_apc = 1'b0;
        f_off = 1'b0;
        case (class_q)
            C_I:      f_src = 1'b1;
            C_LOAD:   begin f_m2r = 2'b01; f_src = 1'b1; end
            C_STORE:  begin f_src = 1'b1; f_off = 1'b1; end
            C_BRANCH: f_npc = 2'b01;
            C_JAL:    begin f_npc = 2'b11; f_m2r = 2'b10; end
            C_JALR:   begin f_npc = 2'b10; f_m2r = 2'b10; f_src = 1'b1; end
            C_LUI:    begin f_m2r = 2'b11; f_src = 1'b1; end
            C_AUIPC:  begin f_src = 1'b1; f_apc = 1'b1; end
            default:  ;
        endcase
    end

    assign wait_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        cnt_d         = '0;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        npc_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        alu_src       = 1'b0;
        alu_a_pc      = 1'b0;
        offset_origin = 1'b0;

        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            npc_op        = f_npc;
            mem_to_reg    = f_m2r;
            alu_src       = f_src;
            alu_a_pc      = f_apc;
            offset_origin = f_off;
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == C_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (class_q == C_BRANCH) begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (class_q == C_LOAD || class_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == C_STORE);
                if (dmem_ready) begin
                    if (class_q == C_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase

        state_o       = state_q;
        illegal_instr = illegal_q;
        timeout_err   = timeout_q;

        // Reset silences every output immediately, aborting any in-flight instruction.
        if (!rst_n) begin
            imem_req      = 1'b0;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            npc_op        = 2'b00;
            reg_write     = 1'b0;
            mem_to_reg    = 2'b00;
            alu_src       = 1'b0;
            alu_a_pc      = 1'b0;
            offset_origin = 1'b0;
            state_o       = 3'd0;
            illegal_instr = 1'b0;
            timeout_err   = 1'b0;
        end

        mem_write = dmem_we;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the MINIRISC-V core. Replaces the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Uses req/ready handshakes to instruction and data memory, with a timeout watchdog.
- Drives the same datapath control fields (next-PC select, write-back select, ALU source, store offset origin), plus AUIPC support and illegal-opcode/timeout halting.

Parameters:
- TIMEOUT_CYCLES, 16: max wait cycles for imem_ready/dmem_ready before halting; 0 disables the watchdog.
- ENABLE_AUIPC, 1: 1 decodes AUIPC (7'b0010111); 0 treats it as illegal.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instruction[6:0] from IR; valid from DECODE onward
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid; IR captures it when ir_write=1
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (store)
- dmem_ready  in  1  data access complete
- ir_write  out  1  IR load strobe
- pc_write  out  1  PC update strobe; one pulse per retired instruction
- npc_op  out  2  00 PC+4, 01 branch, 10 JALR, 11 JAL
- reg_write  out  1  register file write enable
- mem_to_reg  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm
- mem_write  out  1  equals dmem_we
- alu_src  out  1  1 = immediate operand B
- alu_a_pc  out  1  1 = PC as operand A (AUIPC)
- offset_origin  out  1  1 = S-type immediate
- state_o  out  3  current state encoding
- illegal_instr  out  1  sticky: halted on illegal opcode
- timeout_err  out  1  sticky: halted on memory timeout

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset:
  - The rst_n=0 sampled at a rising edge puts state in FETCH and clears the class register, wait counter, illegal_instr and timeout_err.
  - While rst_n=0, every output is forced to 0, including imem_req.
  - Reset mid-instruction aborts it; no pc_write, reg_write or mem_write occurs in that cycle.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: ir_write=1 (combinational, same cycle), go to DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Opcode is classified and registered into the class register: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Later changes on opcode are ignored until the next DECODE.
  - Unknown opcode (or AUIPC with ENABLE_AUIPC=0): go to HALT and set illegal_instr. Otherwise go to EXEC.
- EXEC:
  - BRANCH: pc_write=1, npc_op=01, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=mem_write=1 for STORE.
  - On dmem_ready: STORE asserts pc_write=1, npc_op=00 and goes to FETCH; LOAD goes to WB.
  - Otherwise the wait counter increments.
- WB:
  - reg_write=1, pc_write=1, npc_op per class, go to FETCH.
- Per-class control fields, held constant from EXEC through the last cycle of the instruction and 0 in FETCH/DECODE/HALT:

  | Class | npc_op | mem_to_reg | alu_src | alu_a_pc | offset_origin |
  |---|---|---|---|---|---|
  | R | 00 | 00 | 0 | 0 | 0 |
  | I | 00 | 00 | 1 | 0 | 0 |
  | LOAD | 00 | 01 | 1 | 0 | 0 |
  | STORE | 00 | 00 | 1 | 0 | 1 |
  | BRANCH | 01 | 00 | 0 | 0 | 0 |
  | JAL | 11 | 10 | 0 | 0 | 0 |
  | JALR | 10 | 10 | 1 | 0 | 0 |
  | LUI | 00 | 11 | 1 | 0 | 0 |
  | AUIPC | 00 | 00 | 1 | 1 | 0 |

- Latency (zero wait states), from FETCH entry to pc_write:
  - BRANCH: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - Counter width is clog2(TIMEOUT_CYCLES+1); it clears on entering FETCH or MEM and on every accepted ready.
  - If the counter reaches TIMEOUT_CYCLES while still waiting: go to HALT, set timeout_err.
  - Ready arriving in the same cycle the limit is reached wins, and the transfer proceeds.
  - The counter saturates and does not wrap.
- Ready without request:
  - imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- HALT:
  - Absorbing; only reset exits.
  - All strobes and requests are 0; sticky flags are held.

Test Plan:
- Reset, then ADD (0110011) with imem_ready/dmem_ready always 1 -> state_o 0,1,2,4,0. ir_write in cycle 1. Exactly one pc_write and one reg_write in WB. npc_op=00, mem_to_reg=00, alu_src=0.
- LW (0000011) with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0. WB has mem_to_reg=01, reg_write=1. Total 8 cycles to pc_write.
- SW (0100011) -> dmem_we=mem_write=1 in MEM, offset_origin=1, reg_write never 1, pc_write with npc_op=00.
- BEQ (1100011), JAL (1101111), JALR (1100111), AUIPC (0010111) back-to-back:
  - BEQ: pc_write in EXEC, npc_op=01.
  - JAL: mem_to_reg=10, npc_op=11.
  - JALR: npc_op=10, alu_src=1.
  - AUIPC: alu_a_pc=1.
- Opcode 7'b1111111 -> HALT (state_o=5), illegal_instr=1. No further imem_req even when imem_ready toggles, until rst_n=0 then 1.
- imem_ready held 0 with TIMEOUT_CYCLES=16 -> HALT and timeout_err=1 after 16 wait cycles. Rerun with imem_ready=1 on cycle 16 -> fetch accepted, no error. Assert rst_n=0 during MEM -> no mem_write, state FETCH.
